scarv_cop_dispatch: RTL
=======================

Name: scarv_cop_dispatch

Overview:
Instruction sequencer for the coprocessor. Accepts one encoded instruction at a time from the host CPU over a valid/ready handshake and presents it to the combinational decoder. It then launches the instruction on the functional unit selected by the decoded class and waits for completion. Finally it returns the write-back and exception status to the CPU. It sits between the CPU interface and the decoder plus functional units. Only one instruction is in flight at a time.

Parameters:
TIMEOUT_CYCLES, 64, max EXEC cycles before the instruction is aborted with exception; must be ≥ 2.
CNT_W, 7, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
g_clk  in  1  clock, all state on rising edge
g_reset  in  1  asynchronous, active-high reset
cpu_insn_req  in  1  instruction valid
cpu_insn_ack  out  1  instruction accepted (ready)
cpu_insn_enc  in  32  encoded instruction
cpu_rsp_valid  out  1  response valid
cpu_rsp_ack  in  1  CPU accepts response
cpu_rsp_exc  out  1  illegal instruction / timeout
cpu_rsp_wen  out  1  GPR write enable
cpu_rsp_rd  out  5  GPR destination
cpu_rsp_wdata  out  32  GPR write data
id_encoded  out  32  held instruction, to decoder
id_exception  in  1  decoder illegal flag
id_class  in  4  decoder class
id_rd  in  5  decoder GPR destination
id_cprs_init  in  1  decoder init flag
fu_ivalid  out  16  one-hot launch, bit index = class code
fu_abort  out  1  one-cycle abort pulse on timeout
fu_idone  in  16  per-class completion
fu_wen  in  1  completing unit requests GPR write
fu_wdata  in  32  completing unit result
cprs_init  out  1  one-cycle pulse: clear coprocessor register file

Behaviour:
- Reset state: state IDLE. All outputs 0 except cpu_insn_ack=1. insn register cleared to 0; id_encoded therefore 0.
- States: IDLE, DECODE, EXEC, RESP; state encoding goes in the package.
- IDLE:
  - cpu_insn_ack=1.
  - On cpu_insn_req & ack: latch cpu_insn_enc into insn, go to DECODE.
  - cpu_insn_ack is 0 in every other state.
- DECODE (exactly 1 cycle):
  - Register id_class and id_rd.
  - If id_exception=1: set exc=1, wen=0, go to RESP.
  - Else if id_cprs_init=1: pulse cprs_init for this cycle, set exc=0, wen=0, go to RESP.
  - Else if id_class=0 (no unit): set exc=1, go to RESP.
  - Else: clear timeout counter, go to EXEC.
- EXEC:
  - fu_ivalid[class]=1, held every cycle until completion; all other bits 0.
  - When fu_idone[class]=1: capture wen=fu_wen, wdata=fu_wdata, exc=0, go to RESP. fu_ivalid drops in that same completing cycle's successor.
  - fu_idone bits for other classes are ignored.
  - Counter increments each EXEC cycle. If it reaches TIMEOUT_CYCLES-1 without done: pulse fu_abort, set exc=1, wen=0, go to RESP.
  - Done and timeout in the same cycle: done wins.
- RESP:
  - cpu_rsp_valid=1; exc/wen/rd/wdata are stable while valid.
  - On cpu_rsp_ack: return to IDLE. The next instruction can be accepted no earlier than the following cycle.
  - cpu_rsp_rd = registered id_rd. cpu_rsp_wdata = 0 whenever wen=0.
- Latency:
  - Minimum accept-to-response for exception/init is 2 cycles.
  - A unit completing in its first EXEC cycle gives 3 cycles.
- Reset asserted mid-operation (any state): immediately IDLE. fu_ivalid=0, no abort pulse, response discarded.
- cpu_insn_enc is sampled only on the handshake cycle; later changes are ignored.

Decomposition:
- Shared package/header scarv_cop_dispatch_pkg.vh holds:
  - FSM state localparams.
  - ICLASS codes, reused from the existing class constants header.
  - Default TIMEOUT_CYCLES.
- One natural sub-module: scarv_cop_dispatch_timer, a CNT_W counter with clear/enable and terminal-count output.
- The decoder is instantiated beside this block, not inside it.

Test Plan:
- Legal packed-arith instr, class 1 (PACKED_ARITH):
  - Stimulus: unit asserts done after 4 cycles with wen=1, wdata=32'hDEADBEEF, rd=5.
  - Required: fu_ivalid=16'h0002 for exactly 4 cycles, then cpu_rsp_valid with wen=1, rd=5, wdata=DEADBEEF, exc=0.
- Decoder flags id_exception=1 -> no fu_ivalid bit ever set; cpu_rsp_valid on 2nd cycle after accept with exc=1, wen=0, wdata=0.
- id_cprs_init=1 -> cprs_init high for exactly 1 cycle in DECODE; response exc=0, wen=0.
- Response backpressure: hold cpu_rsp_ack=0 for 10 cycles with a new cpu_insn_req pending -> outputs stable, cpu_insn_ack=0 throughout; new instruction accepted 1 cycle after ack.
- Timeout: unit never completes, TIMEOUT_CYCLES=8 -> fu_abort pulses in the 8th EXEC cycle; response exc=1. Done and timeout coinciding in that cycle -> exc=0 with captured data.
- Reset asserted in EXEC -> fu_ivalid=0 in the same cycle (async), cpu_insn_ack=1 after release, no response is emitted.

Source files
------------

// File: rtl/scarv_cop_dispatch_pkg.sv
// Shared constants for the coprocessor instruction dispatcher.
//   - FSM state encoding (IDLE, DECODE, EXEC, RESP)
//   - Instruction class codes; each code doubles as the bit index
//     into the one-hot functional-unit launch vector
//   - Default timeout length for an executing instruction
package scarv_cop_dispatch_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DECODE = 2'd1;
    localparam logic [1:0] ST_EXEC   = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    // Class 0 means "no functional unit"; the decoder never launches it.
    localparam logic [3:0] ICLASS_NONE         = 4'd0;
    localparam logic [3:0] ICLASS_PACKED_ARITH = 4'd1;
    localparam logic [3:0] ICLASS_TWIDDLE      = 4'd2;
    localparam logic [3:0] ICLASS_LOADSTORE    = 4'd3;
    localparam logic [3:0] ICLASS_RANDOM       = 4'd4;
    localparam logic [3:0] ICLASS_MOVE         = 4'd5;
    localparam logic [3:0] ICLASS_MP           = 4'd6;
    localparam logic [3:0] ICLASS_BITWISE      = 4'd7;

    localparam int DEFAULT_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/scarv_cop_dispatch_timer.sv
// Execution timeout counter.
//   clk, rst : clock and asynchronous active-high reset
//   clr      : synchronous clear to zero (wins over en)
//   en       : increment by one this cycle
//   cnt      : current count
//   tc       : count equals TIMEOUT_CYCLES-1 (the last permitted cycle)
module scarv_cop_dispatch_timer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    localparam logic [CNT_W-1:0] TC_VALUE = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == TC_VALUE);

endmodule

// File: rtl/scarv_cop_dispatch.sv
// Coprocessor instruction sequencer. Accepts one instruction from the CPU,
// holds it for the external decoder, launches the selected functional unit,
// waits for completion (or timeout) and returns the write-back result.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. cpu_insn_req/cpu_insn_ack is the instruction channel (ack is the
// ready); cpu_rsp_valid/cpu_rsp_ack is the response channel. cpu_rsp_* stay
// stable while cpu_rsp_valid is high.
//
// Ports:
//   g_clk, g_reset          clock, asynchronous active-high reset
//   cpu_insn_*              instruction request channel from the CPU
//   cpu_rsp_*               response channel to the CPU
//   id_encoded / id_*       held instruction out, decode results in
//   fu_ivalid, fu_abort     one-hot launch and timeout abort to the units
//   fu_idone, fu_wen/wdata  per-class completion and result from the units
//   cprs_init               one-cycle clear pulse to the coprocessor regfile
module scarv_cop_dispatch
    import scarv_cop_dispatch_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = 7
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        cpu_insn_req,
    output logic        cpu_insn_ack,
    input  logic [31:0] cpu_insn_enc,
    output logic        cpu_rsp_valid,
    input  logic        cpu_rsp_ack,
    output logic        cpu_rsp_exc,
    output logic        cpu_rsp_wen,
    output logic [4:0]  cpu_rsp_rd,
    output logic [31:0] cpu_rsp_wdata,
    output logic [31:0] id_encoded,
    input  logic        id_exception,
    input  logic [3:0]  id_class,
    input  logic [4:0]  id_rd,
    input  logic        id_cprs_init,
    output logic [15:0] fu_ivalid,
    output logic        fu_abort,
    input  logic [15:0] fu_idone,
    input  logic        fu_wen,
    input  logic [31:0] fu_wdata,
    output logic        cprs_init
);

    logic [1:0]  state_d, state_q;
    logic [31:0] insn_d, insn_q;
    logic [3:0]  class_d, class_q;
    logic [4:0]  rd_d, rd_q;
    logic        exc_d, exc_q;
    logic        wen_d, wen_q;
    logic [31:0] wdata_d, wdata_q;

    logic             timer_clr;
    logic             timer_en;
    logic             timer_tc;
    logic [CNT_W-1:0] timer_cnt;
    logic             done_sel;
    logic             abort;
    logic             init_pulse;

    scarv_cop_dispatch_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timer (
        .clk (g_clk),
        .rst (g_reset),
        .clr (timer_clr),
        .en  (timer_en),
        .cnt (timer_cnt),
        .tc  (timer_tc)
    );

    // Only the launched unit's done bit matters; others are ignored.
    assign done_sel = fu_idone[class_q];

    always_comb begin
        state_d    = state_q;
        insn_d     = insn_q;
        class_d    = class_q;
        rd_d       = rd_q;
        exc_d      = exc_q;
        wen_d      = wen_q;
        wdata_d    = wdata_q;
        timer_clr  = 1'b0;
        timer_en   = 1'b0;
        abort      = 1'b0;
        init_pulse = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpu_insn_req) begin
                    insn_d  = cpu_insn_enc;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                class_d = id_class;
                rd_d    = id_rd;
                wdata_d = '0;
                if (id_exception) begin
                    exc_d   = 1'b1;
                    wen_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (id_cprs_init) begin
                    init_pulse = 1'b1;
                    exc_d      = 1'b0;
                    wen_d      = 1'b0;
                    state_d    = ST_RESP;
                end else if (id_class == ICLASS_NONE) begin
                    exc_d   = 1'b1;
                    wen_d   = 1'b0;
                    state_d = ST_RESP;
                end else begin
                    timer_clr = 1'b1;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                timer_en = 1'b1;
                // Completion takes priority over a coinciding timeout.
                if (done_sel) begin
                    exc_d   = 1'b0;
                    wen_d   = fu_wen;
                    wdata_d = fu_wdata;
                    state_d = ST_RESP;
                end else if (timer_tc) begin
                    abort   = 1'b1;
                    exc_d   = 1'b1;
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    state_d = ST_RESP;
                end
            end
            default: begin
                if (cpu_rsp_ack) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state_q <= ST_IDLE;
            insn_q  <= '0;
            class_q <= '0;
            rd_q    <= '0;
            exc_q   <= 1'b0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            insn_q  <= insn_d;
            class_q <= class_d;
            rd_q    <= rd_d;
            exc_q   <= exc_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
        end
    end

    // Launch vector is decoded from state so an async reset drops it at once.
    assign fu_ivalid     = (state_q == ST_EXEC) ? (16'd1 << class_q) : 16'd0;
    assign fu_abort      = abort;
    assign cprs_init     = init_pulse;
    assign cpu_insn_ack  = (state_q == ST_IDLE);
    assign cpu_rsp_valid = (state_q == ST_RESP);
    assign cpu_rsp_exc   = exc_q;
    assign cpu_rsp_wen   = wen_q;
    assign cpu_rsp_rd    = rd_q;
    assign cpu_rsp_wdata = wen_q ? wdata_q : 32'd0;
    assign id_encoded    = insn_q;

endmodule
